// File: rtl/fft128_burst_if.sv
// Burst I/O bundle for the 128-point FFT core: frame control, sample input, bin output.
// The master side drives frames in; the slave side (the core) produces bins.
interface fft128_burst_if #(
    parameter int DW    = 32,
    parameter int NLOG2 = 7
);
    logic                 start;
    logic                 unload;
    logic [DW-1:0]        xn_re;
    logic [DW-1:0]        xn_im;
    logic                 fwd_inv;
    logic                 fwd_inv_we;
    logic [2*NLOG2-1:0]   scale_sch;
    logic                 scale_sch_we;
    logic                 rfd;
    logic [NLOG2-1:0]     xn_index;
    logic                 busy;
    logic                 edone;
    logic                 done;
    logic                 dv;
    logic [NLOG2-1:0]     xk_index;
    logic [DW-1:0]        xk_re;
    logic [DW-1:0]        xk_im;

    modport master (
        output start, unload, xn_re, xn_im, fwd_inv, fwd_inv_we, scale_sch, scale_sch_we,
        input  rfd, xn_index, busy, edone, done, dv, xk_index, xk_re, xk_im
    );

    modport slave (
        input  start, unload, xn_re, xn_im, fwd_inv, fwd_inv_we, scale_sch, scale_sch_we,
        output rfd, xn_index, busy, edone, done, dv, xk_index, xk_re, xk_im
    );
endinterface

// File: rtl/fft128_burst.sv
// 128-point radix-2 DIT FFT/IFFT: bit-reversed load, in-place iterative butterflies
// (one per cycle, 3-stage pipeline), natural-order burst readout.
module fft128_burst #(
    parameter int DW    = 32,
    parameter int TW    = 18,
    parameter int NLOG2 = 7
) (
    input  logic                clk,
    input  logic                sclr,
    fft128_burst_if.slave       bus
);
    localparam int N = 1 << NLOG2;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_READY, S_UNLOAD} state_t;
    state_t state_reg, state_next;

    logic [NLOG2-1:0]   ld_cnt_reg, out_cnt_reg, xk_index_reg;
    logic [6:0]         phase_reg;
    logic [2:0]         stage_reg;
    logic               fwd_inv_reg, fwd_frame_reg;
    logic [2*NLOG2-1:0] sch_reg, sch_frame_reg;
    logic               done_reg, dv_reg;
    logic [DW-1:0]      xk_re_reg, xk_im_reg;
    logic               load_we, issue, out_rd, last_calc, start_frame;

    // Quarter-wave cosine, round(cos(2*pi*i/128) * 2^16) for i = 0..32.
    function automatic int quarter_cos(input int i);
        case (i)
            0:  return 65536;  1:  return 65457;  2:  return 65220;  3:  return 64827;
            4:  return 64277;  5:  return 63572;  6:  return 62714;  7:  return 61705;
            8:  return 60547;  9:  return 59244;  10: return 57798;  11: return 56212;
            12: return 54491;  13: return 52639;  14: return 50660;  15: return 48559;
            16: return 46341;  17: return 44011;  18: return 41576;  19: return 39040;
            20: return 36410;  21: return 33692;  22: return 30893;  23: return 28020;
            24: return 25080;  25: return 22078;  26: return 19024;  27: return 15924;
            28: return 12785;  29: return 9616;   30: return 6424;   31: return 3216;
            default: return 0;
        endcase
    endfunction

    logic signed [TW-1:0] cos_rom [64];
    logic signed [TW-1:0] sin_rom [64];

    for (genvar gi = 0; gi < 64; gi++) begin : g_rom
        localparam int C = (gi <= 32) ? quarter_cos(gi) : -quarter_cos(64 - gi);
        localparam int S = (gi <= 32) ? quarter_cos(32 - gi) : quarter_cos(gi - 32);
        assign cos_rom[gi] = TW'(C);
        assign sin_rom[gi] = TW'(S);
    end

    // Sample n lands at bit-reversed n so the DIT output comes out in natural order.
    logic [NLOG2-1:0] ld_addr;
    for (genvar gi = 0; gi < NLOG2; gi++) begin : g_bitrev
        assign ld_addr[gi] = ld_cnt_reg[NLOG2-1-gi];
    end

    // Butterfly j of stage s: span h = 2^s, pair (top, top+h), twiddle k = (j mod h) * 64/h.
    logic [6:0] bf_j, span_mask7, top_addr, bot_addr;
    logic [5:0] span_mask6, tw_k;
    always_comb begin
        bf_j       = {1'b0, phase_reg[5:0]};
        span_mask7 = (7'd1 << stage_reg) - 7'd1;
        span_mask6 = (6'd1 << stage_reg) - 6'd1;
        top_addr   = ((bf_j >> stage_reg) << ({1'b0, stage_reg} + 4'd1)) | (bf_j & span_mask7);
        bot_addr   = top_addr | (7'd1 << stage_reg);
        tw_k       = (phase_reg[5:0] & span_mask6) << (3'd6 - stage_reg);
    end

    always_comb begin
        state_next  = state_reg;
        load_we     = 1'b0;
        issue       = 1'b0;
        out_rd      = 1'b0;
        last_calc   = 1'b0;
        start_frame = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next  = S_LOAD;
                    start_frame = 1'b1;
                end
            end
            S_LOAD: begin
                load_we = 1'b1;
                if (ld_cnt_reg == '1) state_next = S_CALC;
            end
            S_CALC: begin
                issue = ~phase_reg[6];
                // Phases 64/65 drain the pipeline so the next stage never reads stale pairs.
                if (stage_reg == 3'd6 && phase_reg == 7'd65) begin
                    last_calc  = 1'b1;
                    state_next = S_READY;
                end
            end
            S_READY: begin
                if (bus.start) begin
                    state_next  = S_LOAD;
                    start_frame = 1'b1;
                end else if (bus.unload) begin
                    state_next = S_UNLOAD;
                    out_rd     = 1'b1;
                end
            end
            S_UNLOAD: begin
                out_rd = 1'b1;
                if (out_cnt_reg == '1) state_next = S_READY;
            end
            default: state_next = S_IDLE;
        endcase
    end

    logic [2*DW-1:0] mem [N];
    logic [2*DW-1:0] a_rd_reg, b_rd_reg;
    logic [6:0]      wa1_reg, wb1_reg, wa2_reg, wb2_reg;
    logic            v1_reg, v2_reg;
    logic signed [TW-1:0] w_re_reg, w_im_reg;
    logic signed [DW-1:0] a2_re_reg, a2_im_reg, p_re_reg, p_im_reg;

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_reg     <= S_IDLE;
            ld_cnt_reg    <= '0;
            phase_reg     <= '0;
            stage_reg     <= '0;
            out_cnt_reg   <= '0;
            xk_index_reg  <= '0;
            xk_re_reg     <= '0;
            xk_im_reg     <= '0;
            done_reg      <= 1'b0;
            dv_reg        <= 1'b0;
            fwd_inv_reg   <= 1'b1;
            fwd_frame_reg <= 1'b1;
            sch_reg       <= '0;
            sch_frame_reg <= '0;
            v1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (bus.fwd_inv_we)   fwd_inv_reg <= bus.fwd_inv;
            if (bus.scale_sch_we) sch_reg     <= bus.scale_sch;
            if (start_frame) begin
                fwd_frame_reg <= fwd_inv_reg;
                sch_frame_reg <= sch_reg;
                ld_cnt_reg    <= '0;
            end else if (load_we) begin
                ld_cnt_reg <= ld_cnt_reg + 1'b1;
            end
            if (state_reg == S_CALC && !last_calc) begin
                if (phase_reg == 7'd65) begin
                    phase_reg <= '0;
                    stage_reg <= stage_reg + 3'd1;
                end else begin
                    phase_reg <= phase_reg + 7'd1;
                end
            end else begin
                phase_reg <= '0;
                stage_reg <= '0;
            end
            done_reg <= last_calc;
            dv_reg   <= out_rd;
            if (out_rd) begin
                xk_index_reg           <= out_cnt_reg;
                {xk_re_reg, xk_im_reg} <= mem[out_cnt_reg];
                out_cnt_reg            <= out_cnt_reg + 1'b1;
            end
            v1_reg <= issue;
            v2_reg <= v1_reg;
        end
    end

    // Complex product W*b at full precision; keep bits [DW+15:16] (>>>16, wrap to DW).
    logic signed [DW-1:0]    b_re, b_im;
    logic signed [DW+TW-1:0] prod_rr, prod_ii, prod_ri, prod_ir;
    logic signed [DW+TW:0]   m_re, m_im;
    logic                    unused_bits;
    always_comb begin
        b_re    = b_rd_reg[2*DW-1:DW];
        b_im    = b_rd_reg[DW-1:0];
        prod_rr = (DW+TW)'(b_re) * (DW+TW)'(w_re_reg);
        prod_ii = (DW+TW)'(b_im) * (DW+TW)'(w_im_reg);
        prod_ri = (DW+TW)'(b_re) * (DW+TW)'(w_im_reg);
        prod_ir = (DW+TW)'(b_im) * (DW+TW)'(w_re_reg);
        m_re    = (DW+TW+1)'(prod_rr) - (DW+TW+1)'(prod_ii);
        m_im    = (DW+TW+1)'(prod_ri) + (DW+TW+1)'(prod_ir);
    end
    assign unused_bits = ^{m_re[DW+TW:DW+16], m_re[15:0], m_im[DW+TW:DW+16], m_im[15:0]};

    always_ff @(posedge clk) begin
        a_rd_reg  <= mem[top_addr];
        b_rd_reg  <= mem[bot_addr];
        wa1_reg   <= top_addr;
        wb1_reg   <= bot_addr;
        w_re_reg  <= cos_rom[tw_k];
        w_im_reg  <= fwd_frame_reg ? -sin_rom[tw_k] : sin_rom[tw_k];
        a2_re_reg <= a_rd_reg[2*DW-1:DW];
        a2_im_reg <= a_rd_reg[DW-1:0];
        p_re_reg  <= m_re[DW+15:16];
        p_im_reg  <= m_im[DW+15:16];
        wa2_reg   <= wa1_reg;
        wb2_reg   <= wb1_reg;
    end

    // Stage scaling is applied after the wrapped sum; stage_reg is stable while a stage drains.
    logic [1:0]           scale_sh;
    logic signed [DW-1:0] sum_re, sum_im, dif_re, dif_im;
    logic [NLOG2-1:0]     wa_addr, wb_addr;
    logic [2*DW-1:0]      wa_data, wb_data;
    logic                 wa_en, wb_en;
    always_comb begin
        scale_sh = sch_frame_reg[2*stage_reg +: 2];
        sum_re   = a2_re_reg + p_re_reg;
        sum_im   = a2_im_reg + p_im_reg;
        dif_re   = a2_re_reg - p_re_reg;
        dif_im   = a2_im_reg - p_im_reg;
        wb_en    = v2_reg;
        wb_addr  = wb2_reg;
        wb_data  = {dif_re >>> scale_sh, dif_im >>> scale_sh};
        if (load_we) begin
            wa_en   = 1'b1;
            wa_addr = ld_addr;
            wa_data = {bus.xn_re, bus.xn_im};
        end else begin
            wa_en   = v2_reg;
            wa_addr = wa2_reg;
            wa_data = {sum_re >>> scale_sh, sum_im >>> scale_sh};
        end
    end

    always_ff @(posedge clk) begin
        if (wa_en) mem[wa_addr] <= wa_data;
        if (wb_en) mem[wb_addr] <= wb_data;
    end

    assign bus.rfd      = (state_reg == S_LOAD);
    assign bus.xn_index = ld_cnt_reg;
    assign bus.busy     = (state_reg == S_CALC);
    assign bus.edone    = last_calc;
    assign bus.done     = done_reg;
    assign bus.dv       = dv_reg;
    assign bus.xk_index = xk_index_reg;
    assign bus.xk_re    = xk_re_reg;
    assign bus.xk_im    = xk_im_reg;
endmodule

// File: tb/tb_fft128_burst.sv
// Directed bench for fft128_burst: impulse, short pulse, DC with scaling, inverse,
// handshake timing and abort by sclr mid-transform.
module tb_fft128_burst;
    logic clk = 1'b0;
    logic sclr;
    always #5 clk = ~clk;

    fft128_burst_if bus();
    fft128_burst dut (.clk(clk), .sclr(sclr), .bus(bus.slave));

    int n_run  = 0;
    int n_fail = 0;
    int xin_re [128];
    int xin_im [128];
    int xo_re  [128];
    int xo_im  [128];

    task automatic check_val(input string tag, input longint got, input longint exp, input longint tol);
        longint diff;
        n_run++;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (+-%0d)", tag, got, exp, tol);
        end
    endtask

    task automatic check_bin(input string name, input int k, input int exp_re, input int exp_im);
        check_val($sformatf("%s_re[%0d]", name, k), xo_re[k], exp_re, 16);
        check_val($sformatf("%s_im[%0d]", name, k), xo_im[k], exp_im, 16);
    endtask

    task automatic clear_input();
        for (int i = 0; i < 128; i++) begin
            xin_re[i] = 0;
            xin_im[i] = 0;
        end
    endtask

    task automatic set_cfg(input logic fi, input logic [13:0] sch);
        @(negedge clk);
        bus.fwd_inv      = fi;
        bus.fwd_inv_we   = 1'b1;
        bus.scale_sch    = sch;
        bus.scale_sch_we = 1'b1;
        @(negedge clk);
        bus.fwd_inv_we   = 1'b0;
        bus.scale_sch_we = 1'b0;
    endtask

    task automatic load_frame(input string name);
        int n;
        int idx_bad;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        idx_bad = 0;
        while (bus.rfd && n < 200) begin
            if (bus.xn_index != 7'(n)) idx_bad++;
            bus.xn_re = xin_re[n % 128];
            bus.xn_im = xin_im[n % 128];
            @(negedge clk);
            n++;
        end
        check_val({name, "_rfd_cycles"}, n, 128, 0);
        check_val({name, "_xn_index"}, idx_bad, 0, 0);
    endtask

    task automatic wait_done(input string name, input bit poke_start);
        int c;
        int edone_at;
        int done_at;
        int busy_cnt;
        int rfd_seen;
        c = 0;
        edone_at = -1;
        done_at = -1;
        busy_cnt = 0;
        rfd_seen = 0;
        while (done_at < 0 && c < 1000) begin
            if (bus.edone) edone_at = c;
            if (bus.busy) busy_cnt++;
            if (bus.rfd) rfd_seen++;
            if (bus.done) done_at = c;
            else begin
                bus.start = poke_start && (c == 20);
                @(negedge clk);
                c++;
            end
        end
        bus.start = 1'b0;
        check_val({name, "_done_seen"}, longint'(done_at >= 0), 1, 0);
        check_val({name, "_done_in_600"}, longint'(done_at <= 600), 1, 0);
        check_val({name, "_edone_to_done"}, done_at - edone_at, 1, 0);
        check_val({name, "_busy_until_edone"}, busy_cnt, done_at, 0);
        check_val({name, "_busy_low_at_done"}, bus.busy, 0, 0);
        check_val({name, "_no_rfd_in_calc"}, rfd_seen, 0, 0);
        @(negedge clk);
        check_val({name, "_done_pulse"}, bus.done, 0, 0);
        $display("[TB] frame %s transformed, done %0d cycles after last sample", name, done_at);
    endtask

    task automatic unload_frame(input string name);
        int n;
        int idx_bad;
        @(negedge clk);
        bus.unload = 1'b1;
        @(negedge clk);
        bus.unload = 1'b0;
        n = 0;
        idx_bad = 0;
        while (bus.dv && n < 200) begin
            if (bus.xk_index != 7'(n)) idx_bad++;
            xo_re[n % 128] = $signed(bus.xk_re);
            xo_im[n % 128] = $signed(bus.xk_im);
            @(negedge clk);
            n++;
        end
        check_val({name, "_dv_cycles"}, n, 128, 0);
        check_val({name, "_xk_index"}, idx_bad, 0, 0);
        $display("[TB] frame %s unloaded, %0d bins, X[0]=(%0d,%0d)", name, n, xo_re[0], xo_im[0]);
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.unload       = 1'b0;
        bus.xn_re        = '0;
        bus.xn_im        = '0;
        bus.fwd_inv      = 1'b1;
        bus.fwd_inv_we   = 1'b0;
        bus.scale_sch    = '0;
        bus.scale_sch_we = 1'b0;
        sclr = 1'b1;
        repeat (3) @(negedge clk);
        sclr = 1'b0;
        @(negedge clk);

        check_val("rst_rfd", bus.rfd, 0, 0);
        check_val("rst_busy", bus.busy, 0, 0);
        check_val("rst_dv", bus.dv, 0, 0);
        check_val("rst_done", bus.done, 0, 0);
        check_val("rst_edone", bus.edone, 0, 0);
        check_val("rst_xn_index", bus.xn_index, 0, 0);
        check_val("rst_xk_index", bus.xk_index, 0, 0);
        check_val("rst_xk_re", bus.xk_re, 0, 0);

        // Impulse: flat spectrum; start is poked mid-transform and must be ignored.
        clear_input();
        xin_re[0] = 65536;
        set_cfg(1'b1, 14'h0000);
        load_frame("impulse");
        wait_done("impulse", 1'b1);
        unload_frame("impulse");
        for (int k = 0; k < 128; k++) check_bin("impulse", k, 65536, 0);

        // Five unit samples: X[k] = sum_{n<5} exp(-j2*pi*k*n/128).
        clear_input();
        for (int n = 0; n < 5; n++) xin_re[n] = 65536;
        load_frame("pulse5");
        wait_done("pulse5", 1'b0);
        unload_frame("pulse5");
        check_bin("pulse5", 0, 327680, 0);
        check_bin("pulse5", 64, 65536, 0);
        check_bin("pulse5", 32, 65536, 0);
        check_bin("pulse5", 16, 0, -158218);

        // DC with a halving at every stage: exactly 1.0 in bin 0, nothing elsewhere.
        for (int n = 0; n < 128; n++) begin
            xin_re[n] = 65536;
            xin_im[n] = 0;
        end
        set_cfg(1'b1, 14'h1555);
        load_frame("dc_scaled");
        wait_done("dc_scaled", 1'b0);
        unload_frame("dc_scaled");
        for (int k = 0; k < 128; k++) check_bin("dc_scaled", k, (k == 0) ? 65536 : 0, 0);

        // Inverse of a delayed impulse: X[k] = exp(+j2*pi*k/128); second unload re-reads.
        clear_input();
        xin_re[1] = 65536;
        set_cfg(1'b0, 14'h0000);
        load_frame("inverse");
        wait_done("inverse", 1'b0);
        unload_frame("inverse");
        check_bin("inverse", 0, 65536, 0);
        check_bin("inverse", 16, 46341, 46341);
        check_bin("inverse", 32, 0, 65536);
        check_bin("inverse", 64, -65536, 0);
        check_bin("inverse", 96, 0, -65536);
        unload_frame("inverse_reread");
        check_bin("reread", 32, 0, 65536);
        check_bin("reread", 96, 0, -65536);

        // Abort mid-transform; sclr also restores forward direction and unity schedule.
        set_cfg(1'b0, 14'h1555);
        load_frame("aborted");
        repeat (100) @(negedge clk);
        check_val("abort_busy_before", bus.busy, 1, 0);
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        check_val("abort_busy", bus.busy, 0, 0);
        check_val("abort_rfd", bus.rfd, 0, 0);
        check_val("abort_dv", bus.dv, 0, 0);
        check_val("abort_done", bus.done, 0, 0);
        load_frame("after_sclr");
        wait_done("after_sclr", 1'b0);
        unload_frame("after_sclr");
        check_bin("after_sclr", 0, 65536, 0);
        check_bin("after_sclr", 16, 46341, -46341);
        check_bin("after_sclr", 32, 0, -65536);
        check_bin("after_sclr", 64, -65536, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
